demux1_4_tdm: RTL and testbench
===============================

Name: demux1_4_tdm

Overview:
Time-division demultiplexer: receives a word stream carrying 4 interleaved channels (slot 0..3, slot 0 flagged by sof) and routes each slot to its own channel output. It is the receive-side counterpart of the 4:1 selector (mux4_1), which builds the stream by stepping {s1,s0} through 0..3. A lock FSM hunts for sof, tracks slot order and reports framing errors. Outputs for a frame update atomically, one cycle after the frame completes.

Parameters:
WIDTH, 8, bits per channel word
NSLOT, 4, slots per frame; fixed at 4 in this revision, and the slot counter is 2 bits

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous, active-high reset
din  input  WIDTH  slot data word
in_valid  input  1  din and sof qualify this cycle
sof  input  1  start of frame; meaningful only with in_valid; marks slot 0
ch0  output  WIDTH  channel 0 word of the last complete frame
ch1  output  WIDTH  channel 1 word
ch2  output  WIDTH  channel 2 word
ch3  output  WIDTH  channel 3 word
frame_valid  output  1  1-cycle pulse; ch0..ch3 updated this cycle
sync_err  output  1  1-cycle pulse on framing error
locked  output  1  FSM in LOCKED
slot  output  2  next expected slot index {s1,s0}

Behaviour:
- Reset (rst=1 at a clk edge): ch0..ch3=0, frame_valid=0, sync_err=0, locked=0, slot=0, staging registers=0, state=HUNT. Reset mid-frame discards the partial frame.
- Cycles with in_valid=0: no state change. frame_valid and sync_err still deassert after their single-cycle pulse.
- State HUNT:
  - in_valid&sof: stage din as slot 0, set slot=1, go to LOCKED.
  - in_valid&!sof: drop the word, no error.
- State LOCKED, in_valid, expected slot k:
  - k=0, sof=1: stage slot 0, slot=1.
  - k=0, sof=0: sync_err pulse, drop the word, go to HUNT, slot=0.
  - k in 1..3, sof=0: stage din into slot k, slot=k+1 with wrap 3->0.
  - k in 1..3, sof=1: sync_err pulse. Discard the partial frame. Treat the word as a new slot 0 (stage it, slot=1, stay LOCKED).
  - k=3 accepted: next edge copies staging 0..2 plus the slot-3 word into ch0..ch3 together, and frame_valid=1 for one cycle.
- Latency: the slot-3 word accepted at edge N appears on ch3, with frame_valid=1, after edge N+1. ch* hold their value until the next complete frame.
- Back-to-back frames at in_valid=1 every cycle are sustained; frame_valid pulses once every 4 cycles.
- A sof arriving in the cycle frame_valid pulses is legal. The completed frame still publishes.
- locked reflects the registered state. slot is the registered counter; it is 0 in HUNT.

Decomposition:
- Package demux_pkg holds:
  - typedef for the state enum {HUNT, LOCKED};
  - localparam NSLOT=4;
  - slot index typedef as logic [1:0].
- Sub-module tdm_slot_ctr: the 2-bit wrapping slot counter with load-to-1 (on sof) and clear (on error/HUNT).
- FSM, staging registers and output registers stay in demux1_4_tdm.

Test Plan:
1. Reset, then one frame sof/din=A0,A1,A2,A3 on consecutive cycles -> one cycle after A3: ch0..3=A0,A1,A2,A3, frame_valid=1 for 1 cycle, locked=1, sync_err never asserted.
2. Three words with no sof (11,22,33), then a frame 01,02,03,04 -> first three dropped, no sync_err, locked rises on word 01, ch=01,02,03,04.
3. Locked, then sof on slot 2 (din=55), followed by 66,77,88 -> sync_err=1 for 1 cycle, no frame_valid for the broken frame, ch=55,66,77,88 one cycle after 88.
4. Locked, expected slot 0 but sof=0 (din=99) -> sync_err pulse, locked=0, slot=0; next sof frame relocks and publishes correctly.
5. Frame with in_valid gaps (0,1,3 idle cycles between slots) -> same ch values as the gapless frame, frame_valid exactly once, ch unchanged until completion.
6. rst asserted after slot 1 of a frame -> all outputs 0 on the next edge. A new full frame after rst releases publishes normally, with no mixing of pre-reset data.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types for the 1:4 TDM demultiplexer.
package demux_pkg;
  localparam int NSLOT = 4;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  typedef logic [1:0] slot_t;

  // Per-cycle control decoded from the lock FSM.
  typedef struct packed {
    logic  stage_en;   // write din into staging slot stage_idx
    slot_t stage_idx;
    logic  load1;      // slot counter <- 1 (word taken as slot 0)
    logic  adv;        // slot counter <- slot + 1
    logic  clr;        // slot counter <- 0
    logic  err;        // framing error this cycle
    logic  pend;       // slot 3 accepted: publish on the next edge
  } ctl_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// 2-bit wrapping slot counter: clear beats load-to-1 beats advance.
module tdm_slot_ctr
  import demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  load1,
  input  logic  adv,
  output slot_t slot
);

  // Next expected slot; the natural 2-bit overflow gives the 3->0 wrap.
  always_ff @(posedge clk) begin
    if (rst || clr)  slot <= 2'd0;
    else if (load1)  slot <= 2'd1;
    else if (adv)    slot <= slot + 2'd1;
  end

endmodule

// File: rtl/demux1_4_tdm.sv
// 1:4 time-division demultiplexer with sof-based frame lock.
// Slots are staged as they arrive; a completed frame is copied to the
// channel outputs as one unit on the edge after its slot-3 word.
module demux1_4_tdm
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked,
  output logic [1:0]       slot
);

  state_t state, state_nxt;
  ctl_t   ctl;
  slot_t  slot_q;
  logic   pend_q;

  logic [NSLOT-1:0][WIDTH-1:0] stage;
  logic [NSLOT-1:0][WIDTH-1:0] ch_q;

  tdm_slot_ctr u_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctl.clr),
    .load1 (ctl.load1),
    .adv   (ctl.adv),
    .slot  (slot_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  // Next state: sof locks, a missing sof where slot 0 is due drops lock.
  always_comb begin
    state_nxt = state;
    if (in_valid) begin
      unique case (state)
        HUNT:   if (sof) state_nxt = LOCKED;
        LOCKED: if (!sof && slot_q == 2'd0) state_nxt = HUNT;
      endcase
    end
  end

  // Control decode. An early sof restarts the frame at slot 0, so the
  // stale partial frame is overwritten before it can ever be published.
  always_comb begin
    ctl           = '0;
    ctl.stage_idx = slot_q;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (sof) begin
            ctl.stage_en  = 1'b1;
            ctl.stage_idx = 2'd0;
            ctl.load1     = 1'b1;
          end
        end
        LOCKED: begin
          if (slot_q == 2'd0) begin
            if (sof) begin
              ctl.stage_en  = 1'b1;
              ctl.stage_idx = 2'd0;
              ctl.load1     = 1'b1;
            end else begin
              ctl.err = 1'b1;
              ctl.clr = 1'b1;
            end
          end else if (sof) begin
            ctl.err       = 1'b1;
            ctl.stage_en  = 1'b1;
            ctl.stage_idx = 2'd0;
            ctl.load1     = 1'b1;
          end else begin
            ctl.stage_en = 1'b1;
            ctl.adv      = 1'b1;
            ctl.pend     = (slot_q == 2'd3);
          end
        end
      endcase
    end
  end

  // Staging registers, one per slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else if (ctl.stage_en) begin
      stage[ctl.stage_idx] <= din;
    end
  end

  // Publish: channel outputs load from staging together, pulses are 1 cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q        <= '0;
      pend_q      <= 1'b0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      pend_q      <= ctl.pend;
      frame_valid <= pend_q;
      sync_err    <= ctl.err;
      if (pend_q) ch_q <= stage;
    end
  end

  assign ch0    = ch_q[0];
  assign ch1    = ch_q[1];
  assign ch2    = ch_q[2];
  assign ch3    = ch_q[3];
  assign locked = (state == LOCKED);
  assign slot   = slot_q;

endmodule

// File: tb/tb_demux1_4_tdm.sv
// Randomized + directed bench for demux1_4_tdm against a frame-level model.
module tb_demux1_4_tdm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       in_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] ch0, ch1, ch2, ch3;
  logic       frame_valid, sync_err, locked;
  logic [1:0] slot;

  int checks   = 0;
  int failures = 0;

  demux1_4_tdm #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .sof(sof),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .frame_valid(frame_valid), .sync_err(sync_err),
    .locked(locked), .slot(slot)
  );

  always #5 clk = ~clk;

  // Reference model: words collected into a frame buffer, published whole.
  int m_buf [4];
  int m_ch  [4];
  bit m_locked, m_pend, m_fv, m_err;
  int m_slot;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input bit s, input int d);
    if (r) begin
      foreach (m_buf[i]) begin m_buf[i] = 0; m_ch[i] = 0; end
      m_locked = 0; m_pend = 0; m_fv = 0; m_err = 0; m_slot = 0;
      return;
    end
    m_fv  = 0;
    m_err = 0;
    if (m_pend) begin
      m_ch = m_buf;
      m_fv = 1;
      m_pend = 0;
    end
    if (!v) return;
    if (!m_locked) begin
      if (s) begin m_buf[0] = d; m_slot = 1; m_locked = 1; end
    end else if (m_slot == 0) begin
      if (s) begin m_buf[0] = d; m_slot = 1; end
      else begin m_err = 1; m_locked = 0; end
    end else if (s) begin
      m_err = 1; m_buf[0] = d; m_slot = 1;
    end else begin
      m_buf[m_slot] = d;
      if (m_slot == 3) m_pend = 1;
      m_slot = (m_slot + 1) % 4;
    end
  endtask

  task automatic compare_all();
    chk("ch0", ch0, m_ch[0]);
    chk("ch1", ch1, m_ch[1]);
    chk("ch2", ch2, m_ch[2]);
    chk("ch3", ch3, m_ch[3]);
    chk("frame_valid", frame_valid, m_fv);
    chk("sync_err", sync_err, m_err);
    chk("locked", locked, m_locked);
    chk("slot", slot, m_slot);
  endtask

  // One clock: apply inputs, advance model on the edge, compare after it.
  task automatic step(input bit r, input bit v, input bit s, input int d);
    rst = r; in_valid = v; sof = s; din = d[7:0];
    @(posedge clk);
    model_edge(r, v, s, d);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  int fv_cnt;
  int src_k;
  bit rv, rs;

  initial begin
    // Reset
    step(1, 0, 0, 0);
    step(1, 1, 1, 8'hEE);
    chk("rst_locked", locked, 0);
    chk("rst_ch0", ch0, 0);

    // 1: single frame
    step(0, 1, 1, 8'hA0);
    step(0, 1, 0, 8'hA1);
    step(0, 1, 0, 8'hA2);
    step(0, 1, 0, 8'hA3);
    chk("t1_no_fv_yet", frame_valid, 0);
    step(0, 0, 0, 0);
    chk("t1_fv", frame_valid, 1);
    chk("t1_ch0", ch0, 8'hA0);
    chk("t1_ch3", ch3, 8'hA3);
    step(0, 0, 0, 0);
    chk("t1_fv_pulse", frame_valid, 0);

    // 2: unlocked words without sof are dropped silently
    step(1, 0, 0, 0);
    step(0, 1, 0, 8'h11);
    step(0, 1, 0, 8'h22);
    step(0, 1, 0, 8'h33);
    chk("t2_hunt", locked, 0);
    step(0, 1, 1, 8'h01);
    chk("t2_lock", locked, 1);
    step(0, 1, 0, 8'h02);
    step(0, 1, 0, 8'h03);
    step(0, 1, 0, 8'h04);
    step(0, 0, 0, 0);
    chk("t2_ch1", ch1, 8'h02);

    // 3: early sof on slot 2 restarts the frame
    step(0, 1, 1, 8'h10);
    step(0, 1, 0, 8'h20);
    step(0, 1, 1, 8'h55);
    chk("t3_err", sync_err, 1);
    step(0, 1, 0, 8'h66);
    chk("t3_err_pulse", sync_err, 0);
    step(0, 1, 0, 8'h77);
    step(0, 1, 0, 8'h88);
    step(0, 0, 0, 0);
    chk("t3_ch0", ch0, 8'h55);
    chk("t3_ch3", ch3, 8'h88);

    // 4: missing sof where slot 0 is due drops lock
    step(0, 1, 0, 8'h99);
    chk("t4_err", sync_err, 1);
    chk("t4_unlock", locked, 0);
    step(0, 1, 1, 8'hC0);
    step(0, 1, 0, 8'hC1);
    step(0, 1, 0, 8'hC2);
    step(0, 1, 0, 8'hC3);
    step(0, 0, 0, 0);
    chk("t4_ch2", ch2, 8'hC2);

    // 5: gaps between slots, back-to-back sof on publish cycle
    step(0, 1, 1, 8'hD0);
    step(0, 1, 0, 8'hD1);
    idle(1);
    step(0, 1, 0, 8'hD2);
    idle(3);
    chk("t5_hold", ch0, 8'hC0);
    step(0, 1, 0, 8'hD3);
    step(0, 1, 1, 8'hE0);
    chk("t5_fv", frame_valid, 1);
    chk("t5_ch3", ch3, 8'hD3);

    // 6: reset mid-frame, then a clean frame
    step(0, 1, 0, 8'hE1);
    step(1, 0, 0, 0);
    chk("t6_rst_ch3", ch3, 0);
    chk("t6_rst_slot", slot, 0);
    step(0, 1, 0, 8'hE2);
    step(0, 1, 1, 8'hF0);
    step(0, 1, 0, 8'hF1);
    step(0, 1, 0, 8'hF2);
    step(0, 1, 0, 8'hF3);
    step(0, 0, 0, 0);
    chk("t6_ch1", ch1, 8'hF1);

    // Randomized stream: mostly well-formed with injected framing faults.
    fv_cnt = 0;
    src_k  = 0;
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rs = (src_k == 0);
      if ($urandom_range(0, 29) == 0) rs = ~rs;
      if ($urandom_range(0, 299) == 0) begin
        step(1, rv, rs, $urandom_range(0, 255));
        src_k = 0;
      end else begin
        step(0, rv, rs, $urandom_range(0, 255));
        if (rv) src_k = (src_k + 1) % 4;
      end
      if (m_fv) fv_cnt++;
    end
    checks++;
    if (fv_cnt == 0) begin
      failures++;
      $display("FAIL rand_frames got=%0d exp=>0", fv_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
